dram_pattern_tester: RTL and testbench
======================================

Name: dram_pattern_tester

Overview:
Traffic generator and checker sitting directly upstream of the DRAM controller's user-side port (rd_en/wr_en/addr/data/mask in; data/data_valid/ready/wdf_ready/init_calib_complete out). On a start pulse it writes NUM_BEATS deterministic pattern words to consecutive burst addresses, reads them back and compares each returned word. It reports pass/fail, a saturating error count and the index of the first mismatch. It runs on the controller's user clock; the top level inverts the controller's active-high reset to drive i_rst_n.

Parameters:
APP_ADDR_WIDTH, 28, controller user address width
APP_DATA_WIDTH, 128, user data width; must be a multiple of 32
APP_MASK_WIDTH, 16, byte-mask width (APP_DATA_WIDTH/8)
BASE_ADDR, 0, first beat address
ADDR_STEP, 8, address increment per beat (BL8 on x16 DDR3)
NUM_BEATS, 1024, beats per pass (>=1)
MAX_OUTSTANDING, 16, maximum reads issued but not yet returned (>=1)
PATTERN_SEED, 32'h1234_5678, pattern base value

Ports:
clk  in  1  user clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle start pulse
i_init_calib_complete  in  1  controller calibration done
i_ready  in  1  controller accepts a command
i_wdf_ready  in  1  controller accepts write data
i_data  in  APP_DATA_WIDTH  read data
i_data_valid  in  1  read data valid
o_rd_en  out  1  read request
o_wr_en  out  1  write request (command and data together)
o_addr  out  APP_ADDR_WIDTH  request address
o_data  out  APP_DATA_WIDTH  write data
o_mask  out  APP_MASK_WIDTH  write byte mask (1 = masked)
o_busy  out  1  test in progress
o_done  out  1  test finished, held until next start
o_pass  out  1  valid when o_done; 1 = zero errors
o_err_count  out  16  mismatches, saturates at 16'hFFFF
o_first_err_idx  out  32  beat index of first mismatch; 32'hFFFF_FFFF if none

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_rd_en, o_wr_en, o_busy, o_done, o_pass = 0; o_addr = BASE_ADDR; o_data = 0; o_mask = 0; o_err_count = 0; o_first_err_idx = all ones; all counters 0.
- Pattern for beat idx: v = PATTERN_SEED + idx (32-bit wrap); lane j (bits 32j+31:32j) = v rotated left by 8*(j mod 4). o_mask is always all zeros.
- Address for beat idx = BASE_ADDR + idx*ADDR_STEP, truncated to APP_ADDR_WIDTH (wrap-around permitted).
- States: IDLE, WAIT_CAL, WRITE, READ, DRAIN, DONE.
- IDLE/DONE: i_start=1 -> clear err_count, first_err_idx, o_done, o_pass; set o_busy; go to WAIT_CAL. i_start is ignored in every other state.
- WAIT_CAL: when i_init_calib_complete=1 -> WRITE with wr_idx=0.
- WRITE: o_wr_en=1 with o_addr/o_data for wr_idx. A write is accepted in a cycle where o_wr_en & i_ready & i_wdf_ready. Outputs hold stable until acceptance. On acceptance wr_idx++; on acceptance of beat NUM_BEATS-1 -> READ (o_wr_en low in the next cycle).
- READ: o_rd_en=1 with o_addr for rd_idx whenever outstanding < MAX_OUTSTANDING. A read is accepted on o_rd_en & i_ready; then rd_idx++ and outstanding++. Address stays stable while not accepted. After the last read is accepted -> DRAIN.
- Return path (READ and DRAIN): i_data_valid=1 -> compare i_data with the pattern for chk_idx; then chk_idx++ and outstanding--. If an accept and a return occur in the same cycle, outstanding is unchanged.
- Mismatch: err_count++ (saturating). If this is the first error of the run, capture chk_idx into o_first_err_idx.
- i_data_valid with outstanding=0 in READ/DRAIN: counted as one error; chk_idx and outstanding unchanged. i_data_valid in IDLE/WAIT_CAL/WRITE/DONE is ignored.
- DRAIN: when chk_idx = NUM_BEATS -> DONE. In the same transition: o_busy=0, o_done=1, o_pass=(err_count==0 including the final compare).
- Compare latency: o_err_count reflects a returned beat one cycle after its i_data_valid.
- Reset mid-operation: returns immediately to reset values. Data still returning from the controller is ignored because the state is IDLE.
- i_init_calib_complete dropping after WAIT_CAL is not monitored.

Test Plan:
- NUM_BEATS=4, ideal memory model (i_ready=i_wdf_ready=1, read latency 10 cycles): start -> 4 writes at addresses 0,8,16,24; beat0 lane0=32'h12345678, lane1=32'h34567812; then 4 reads; o_done=1, o_pass=1, o_err_count=0, o_first_err_idx=FFFF_FFFF.
- Model corrupts beat 2 (bit 0 flipped) -> o_pass=0, o_err_count=1, o_first_err_idx=2.
- Random i_ready/i_wdf_ready backpressure (50%) -> no address/data change while stalled; each beat written exactly once; pass.
- MAX_OUTSTANDING=2 with read latency 20 -> o_rd_en never asserted while 2 reads are outstanding; all 4 reads complete; pass.
- Assert i_start before calibration completes; raise i_init_calib_complete 50 cycles later -> no o_wr_en until calibration is done; second i_start while busy is ignored.
- Pull i_rst_n low during READ -> all outputs return to reset values asynchronously; late i_data_valid is ignored; a fresh start passes.

Source files
------------

// File: rtl/dram_pattern_tester.sv
// dram_pattern_tester: traffic generator and checker that sits upstream of the
// user-side port of a DRAM controller. On a start pulse it writes NUM_BEATS
// pattern words to consecutive burst addresses, reads them back and compares
// every returned word against the regenerated pattern.
//
// Ports:
//   clk, i_rst_n                 user clock, asynchronous active-low reset
//   i_start                      single-cycle start pulse (IDLE/DONE only)
//   i_init_calib_complete        controller calibration done
//   i_ready, i_wdf_ready         controller command / write-data acceptance
//   i_data, i_data_valid         read return path
//   o_rd_en, o_wr_en, o_addr,    request side toward the controller
//   o_data, o_mask
//   o_busy, o_done, o_pass       run status (o_pass valid while o_done)
//   o_err_count                  saturating mismatch count
//   o_first_err_idx              beat index of first mismatch, all ones if none
module dram_pattern_tester #(
   parameter int unsigned APP_ADDR_WIDTH  = 28,
   parameter int unsigned APP_DATA_WIDTH  = 128,
   parameter int unsigned APP_MASK_WIDTH  = 16,
   parameter int unsigned BASE_ADDR       = 0,
   parameter int unsigned ADDR_STEP       = 8,
   parameter int unsigned NUM_BEATS       = 1024,
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter logic [31:0] PATTERN_SEED    = 32'h1234_5678
) (
   input  logic                      clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic                      i_init_calib_complete,
   input  logic                      i_ready,
   input  logic                      i_wdf_ready,
   input  logic [APP_DATA_WIDTH-1:0] i_data,
   input  logic                      i_data_valid,
   output logic                      o_rd_en,
   output logic                      o_wr_en,
   output logic [APP_ADDR_WIDTH-1:0] o_addr,
   output logic [APP_DATA_WIDTH-1:0] o_data,
   output logic [APP_MASK_WIDTH-1:0] o_mask,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_pass,
   output logic [15:0]               o_err_count,
   output logic [31:0]               o_first_err_idx
);

   localparam int unsigned NumLanes = APP_DATA_WIDTH / 32;
   localparam int unsigned OutW     = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OutW-1:0] MaxOut   = OutW'(MAX_OUTSTANDING);
   localparam logic [31:0]     LastBeat = 32'(NUM_BEATS - 1);
   localparam logic [31:0]     NumBeats = 32'(NUM_BEATS);

   typedef enum logic [2:0] {
      StIdle,
      StWaitCal,
      StWrite,
      StRead,
      StDrain,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     wr_idx_q, wr_idx_d;
   logic [31:0]     rd_idx_q, rd_idx_d;
   logic [31:0]     chk_idx_q, chk_idx_d;
   logic [OutW-1:0] outstanding_q, outstanding_d;
   logic [15:0]     err_count_q, err_count_d;
   logic [31:0]     first_err_q, first_err_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   logic wr_acc, rd_acc, in_check, ret, stray, mismatch;

   // Lane j carries the beat value rotated left by 8*(j mod 4) bits.
   function automatic logic [APP_DATA_WIDTH-1:0] pattern_word(input logic [31:0] idx);
      logic [31:0]               v;
      logic [APP_DATA_WIDTH-1:0] w;
      v = PATTERN_SEED + idx;
      w = '0;
      for (int j = 0; j < NumLanes; j++) begin
         case (j % 4)
            0:       w[32*j +: 32] = v;
            1:       w[32*j +: 32] = {v[23:0], v[31:24]};
            2:       w[32*j +: 32] = {v[15:0], v[31:16]};
            default: w[32*j +: 32] = {v[7:0], v[31:8]};
         endcase
      end
      return w;
   endfunction

   // Arithmetic is done at the address width so wrap-around is implicit.
   function automatic logic [APP_ADDR_WIDTH-1:0] beat_addr(input logic [31:0] idx);
      return APP_ADDR_WIDTH'(BASE_ADDR) + APP_ADDR_WIDTH'(idx) * APP_ADDR_WIDTH'(ADDR_STEP);
   endfunction

   // Request-side outputs
   always_comb begin
      o_wr_en = (state_q == StWrite);
      o_rd_en = (state_q == StRead) && (outstanding_q < MaxOut);
      o_mask  = '0;
      o_data  = '0;
      o_addr  = APP_ADDR_WIDTH'(BASE_ADDR);
      if (state_q == StWrite) begin
         o_addr = beat_addr(wr_idx_q);
         o_data = pattern_word(wr_idx_q);
      end else if (state_q == StRead) begin
         o_addr = beat_addr(rd_idx_q);
      end
   end

   assign wr_acc   = o_wr_en & i_ready & i_wdf_ready;
   assign rd_acc   = o_rd_en & i_ready;
   assign in_check = (state_q == StRead) || (state_q == StDrain);
   assign ret      = in_check & i_data_valid & (outstanding_q != '0);
   // Data with nothing outstanding is still an error, but no beat is consumed.
   assign stray    = in_check & i_data_valid & (outstanding_q == '0);
   assign mismatch = ret && (i_data != pattern_word(chk_idx_q));

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      wr_idx_d      = wr_idx_q;
      rd_idx_d      = rd_idx_q;
      chk_idx_d     = chk_idx_q;
      outstanding_d = outstanding_q;
      err_count_d   = err_count_q;
      first_err_d   = first_err_q;
      busy_d        = busy_q;
      done_d        = done_q;
      pass_d        = pass_q;

      // Return path, only active in READ/DRAIN through ret/stray/rd_acc
      if ((mismatch || stray) && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
      if (mismatch && (first_err_q == '1)) begin
         first_err_d = chk_idx_q;
      end
      if (ret) begin
         chk_idx_d = chk_idx_q + 32'd1;
      end
      if (rd_acc) begin
         rd_idx_d = rd_idx_q + 32'd1;
      end
      case ({rd_acc, ret})
         2'b10:   outstanding_d = outstanding_q + OutW'(1);
         2'b01:   outstanding_d = outstanding_q - OutW'(1);
         default: outstanding_d = outstanding_q;
      endcase

      unique case (state_q)
         StIdle, StDone: begin
            if (i_start) begin
               err_count_d   = '0;
               first_err_d   = '1;
               done_d        = 1'b0;
               pass_d        = 1'b0;
               busy_d        = 1'b1;
               wr_idx_d      = '0;
               rd_idx_d      = '0;
               chk_idx_d     = '0;
               outstanding_d = '0;
               state_d       = StWaitCal;
            end
         end
         StWaitCal: begin
            if (i_init_calib_complete) begin
               wr_idx_d = '0;
               state_d  = StWrite;
            end
         end
         StWrite: begin
            if (wr_acc) begin
               wr_idx_d = wr_idx_q + 32'd1;
               if (wr_idx_q == LastBeat) begin
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            if (rd_acc && (rd_idx_q == LastBeat)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (chk_idx_q == NumBeats) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_count_d == '0);
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= StIdle;
         wr_idx_q      <= '0;
         rd_idx_q      <= '0;
         chk_idx_q     <= '0;
         outstanding_q <= '0;
         err_count_q   <= '0;
         first_err_q   <= '1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_idx_q      <= wr_idx_d;
         rd_idx_q      <= rd_idx_d;
         chk_idx_q     <= chk_idx_d;
         outstanding_q <= outstanding_d;
         err_count_q   <= err_count_d;
         first_err_q   <= first_err_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
      end
   end

   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_pass          = pass_q;
   assign o_err_count     = err_count_q;
   assign o_first_err_idx = first_err_q;

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Scoreboard bench for dram_pattern_tester (NUM_BEATS=4, MAX_OUTSTANDING=2).
// A memory model drives the controller side on the falling edge; expected
// writes, read addresses and final results are queued per run and popped by
// the monitor whenever the DUT presents the matching event.
module tb_dram_pattern_tester;

   localparam int NB   = 4;
   localparam int MAXO = 2;

   logic         clk;
   logic         i_rst_n;
   logic         i_start;
   logic         i_init_calib_complete;
   logic         i_ready;
   logic         i_wdf_ready;
   logic [127:0] i_data;
   logic         i_data_valid;
   logic         o_rd_en;
   logic         o_wr_en;
   logic [27:0]  o_addr;
   logic [127:0] o_data;
   logic [15:0]  o_mask;
   logic         o_busy;
   logic         o_done;
   logic         o_pass;
   logic [15:0]  o_err_count;
   logic [31:0]  o_first_err_idx;

   dram_pattern_tester #(
      .APP_ADDR_WIDTH  (28),
      .APP_DATA_WIDTH  (128),
      .APP_MASK_WIDTH  (16),
      .BASE_ADDR       (0),
      .ADDR_STEP       (8),
      .NUM_BEATS       (NB),
      .MAX_OUTSTANDING (MAXO),
      .PATTERN_SEED    (32'h1234_5678)
   ) dut (
      .clk                   (clk),
      .i_rst_n               (i_rst_n),
      .i_start               (i_start),
      .i_init_calib_complete (i_init_calib_complete),
      .i_ready               (i_ready),
      .i_wdf_ready           (i_wdf_ready),
      .i_data                (i_data),
      .i_data_valid          (i_data_valid),
      .o_rd_en               (o_rd_en),
      .o_wr_en               (o_wr_en),
      .o_addr                (o_addr),
      .o_data                (o_data),
      .o_mask                (o_mask),
      .o_busy                (o_busy),
      .o_done                (o_done),
      .o_pass                (o_pass),
      .o_err_count           (o_err_count),
      .o_first_err_idx       (o_first_err_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed beats: {lane3, lane2, lane1, lane0}
   logic [127:0] exp_data [NB];
   logic [27:0]  exp_addr [NB];
   initial begin
      exp_data[0] = 128'h78123456_56781234_34567812_12345678;
      exp_data[1] = 128'h79123456_56791234_34567912_12345679;
      exp_data[2] = 128'h7A123456_567A1234_34567A12_1234567A;
      exp_data[3] = 128'h7B123456_567B1234_34567B12_1234567B;
      exp_addr[0] = 28'd0;
      exp_addr[1] = 28'd8;
      exp_addr[2] = 28'd16;
      exp_addr[3] = 28'd24;
   end

   typedef struct {
      logic        pass;
      logic [15:0] cnt;
      logic [31:0] first;
   } res_t;

   typedef struct {
      logic [27:0] addr;
      int          due;
   } rd_t;

   int checks = 0;
   int errors = 0;

   logic [27:0]  q_wr_addr [$];
   logic [127:0] q_wr_data [$];
   logic [27:0]  q_rd_addr [$];
   res_t         q_res     [$];

   rd_t          rq [$];
   logic [127:0] mem [logic [27:0]];

   int  cyc     = 0;
   int  lat     = 10;
   bit  bp      = 0;
   bit  corrupt = 0;
   int  tb_out  = 0;
   bit  wr_pend = 0;
   bit  rd_pend = 0;
   logic [27:0]  pend_addr;
   logic [127:0] pend_data;
   logic [27:0]  rpend_addr;
   logic         prev_done = 1'b0;
   logic [127:0] ret_word;
   bit           ret;
   rd_t          ent;
   res_t         r;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   task automatic checkw(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Memory model and monitor, all on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (wr_pend) begin
            check1("wr_hold_en", o_wr_en, 1'b1);
            checkw("wr_hold_addr", 128'(o_addr), 128'(pend_addr));
            checkw("wr_hold_data", o_data, pend_data);
         end
         if (rd_pend) begin
            check1("rd_hold_en", o_rd_en, 1'b1);
            checkw("rd_hold_addr", 128'(o_addr), 128'(rpend_addr));
         end
         if (o_rd_en) check1("rd_limit", tb_out < MAXO, 1'b1);

         i_ready     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         i_wdf_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;

         ret = 0;
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            ent      = rq.pop_front();
            ret_word = mem.exists(ent.addr) ? mem[ent.addr] : '0;
            if (corrupt && ent.addr == 28'd16) ret_word[0] = ~ret_word[0];
            i_data       = ret_word;
            i_data_valid = 1'b1;
            ret          = 1;
         end else begin
            i_data       = '0;
            i_data_valid = 1'b0;
         end

         wr_pend = 0;
         if (o_wr_en) begin
            if (i_ready && i_wdf_ready) begin
               mem[o_addr] = o_data;
               if (q_wr_addr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL wr_extra actual=write@%0h required=no write", o_addr);
               end else begin
                  checkw("wr_addr", 128'(o_addr), 128'(q_wr_addr.pop_front()));
                  checkw("wr_data", o_data, q_wr_data.pop_front());
               end
            end else begin
               wr_pend   = 1;
               pend_addr = o_addr;
               pend_data = o_data;
            end
         end

         rd_pend = 0;
         if (o_rd_en) begin
            if (i_ready) begin
               rq.push_back('{addr: o_addr, due: cyc + lat});
               tb_out++;
               if (q_rd_addr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rd_extra actual=read@%0h required=no read", o_addr);
               end else begin
                  checkw("rd_addr", 128'(o_addr), 128'(q_rd_addr.pop_front()));
               end
            end else begin
               rd_pend    = 1;
               rpend_addr = o_addr;
            end
         end
         if (ret && tb_out > 0) tb_out--;

         if (o_done && !prev_done) begin
            if (q_res.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected actual=done required=no done");
            end else begin
               r = q_res.pop_front();
               check1("done_pass", o_pass, r.pass);
               checkw("done_err_count", 128'(o_err_count), 128'(r.cnt));
               checkw("done_first_idx", 128'(o_first_err_idx), 128'(r.first));
               check1("done_busy", o_busy, 1'b0);
            end
         end
         prev_done = o_done;
      end
   end

   task automatic push_run(input bit bad);
      for (int i = 0; i < NB; i++) begin
         q_wr_addr.push_back(exp_addr[i]);
         q_wr_data.push_back(exp_data[i]);
         q_rd_addr.push_back(exp_addr[i]);
      end
      if (bad) q_res.push_back('{pass: 1'b0, cnt: 16'd1, first: 32'd2});
      else     q_res.push_back('{pass: 1'b1, cnt: 16'd0, first: 32'hFFFF_FFFF});
   endtask

   task automatic start_pulse();
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!o_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check1(name, o_done, 1'b1);
      repeat (3) @(negedge clk);
      checkw("wr_queue_empty", 128'(q_wr_addr.size()), 128'(0));
      checkw("rd_queue_empty", 128'(q_rd_addr.size()), 128'(0));
      checkw("res_queue_empty", 128'(q_res.size()), 128'(0));
   endtask

   task automatic check_reset_values(input string tag);
      check1({tag, "_rd_en"}, o_rd_en, 1'b0);
      check1({tag, "_wr_en"}, o_wr_en, 1'b0);
      check1({tag, "_busy"}, o_busy, 1'b0);
      check1({tag, "_done"}, o_done, 1'b0);
      check1({tag, "_pass"}, o_pass, 1'b0);
      checkw({tag, "_addr"}, 128'(o_addr), 128'(28'd0));
      checkw({tag, "_data"}, o_data, 128'd0);
      checkw({tag, "_mask"}, 128'(o_mask), 128'(16'd0));
      checkw({tag, "_err_count"}, 128'(o_err_count), 128'(16'd0));
      checkw({tag, "_first_idx"}, 128'(o_first_err_idx), 128'(32'hFFFF_FFFF));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      int n;
      i_rst_n               = 1'b0;
      i_start               = 1'b0;
      i_init_calib_complete = 1'b1;
      i_ready               = 1'b1;
      i_wdf_ready           = 1'b1;
      i_data                = '0;
      i_data_valid          = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      i_rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Ideal memory, latency 10
      lat = 10;
      push_run(0);
      start_pulse();
      wait_done("ideal_done");

      // Beat 2 returned with bit 0 flipped
      corrupt = 1;
      push_run(1);
      start_pulse();
      wait_done("corrupt_done");
      corrupt = 0;

      // Random backpressure on both ready inputs
      bp = 1;
      push_run(0);
      start_pulse();
      wait_done("backpressure_done");
      bp = 0;
      repeat (2) @(negedge clk);

      // Long read latency exercises the outstanding limit
      lat = 20;
      push_run(0);
      start_pulse();
      wait_done("latency20_done");
      lat = 10;

      // Start before calibration; second start while busy is ignored
      i_init_calib_complete = 1'b0;
      push_run(0);
      start_pulse();
      seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (o_wr_en) seen = 1;
      end
      check1("no_write_before_cal", seen, 1'b0);
      check1("busy_waiting_cal", o_busy, 1'b1);
      i_init_calib_complete = 1'b1;
      n = 0;
      while (!o_wr_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      check1("write_after_cal", o_wr_en, 1'b1);
      start_pulse();
      wait_done("cal_done");

      // Reset in the middle of READ
      push_run(0);
      start_pulse();
      n = 0;
      while (rq.size() == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkw("reached_read", 128'(rq.size() > 0), 128'(1));
      #2;
      i_rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      q_wr_addr.delete();
      q_wr_data.delete();
      q_rd_addr.delete();
      q_res.delete();
      tb_out  = 0;
      wr_pend = 0;
      rd_pend = 0;
      repeat (3) @(negedge clk);
      #2;
      i_rst_n = 1'b1;
      n = 0;
      while (rq.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checkw("late_data_err_count", 128'(o_err_count), 128'(16'd0));
      check1("late_data_done", o_done, 1'b0);
      check1("late_data_busy", o_busy, 1'b0);
      push_run(0);
      start_pulse();
      wait_done("after_reset_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
